// File: rtl/bp_fe_pred_write_sched.sv
// bp_fe_pred_write_sched
// Owns the single write port of one frontend predictor table (BTB/BHT).
// After reset it sweeps every entry with a clear write. It then arbitrates
// redirect (mispredict) training against attaboy (correct-prediction)
// training.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   init_done_o             clear sweep finished (registered)
//   redir_*                 redirect update in, ready/valid via redir_ready_o
//   ata_*                   attaboy update in; ata_yumi_o consumes it and
//                           ata_drop_o flags that it was discarded
//   w_v_o/w_clr_o/w_idx_o/
//   w_upd_o, w_yumi_i       table write request and its acceptance
module bp_fe_pred_write_sched #(
    parameter int bp_params_p = 0,  // e_bp_default_cfg
    parameter int idx_width_p = 6,
    parameter int upd_width_p = 8,
    parameter int fifo_els_p  = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    output logic                   init_done_o,
    input  logic                   redir_v_i,
    input  logic [idx_width_p-1:0] redir_idx_i,
    input  logic [upd_width_p-1:0] redir_upd_i,
    input  logic                   redir_clr_i,
    output logic                   redir_ready_o,
    input  logic                   ata_v_i,
    input  logic [idx_width_p-1:0] ata_idx_i,
    input  logic [upd_width_p-1:0] ata_upd_i,
    output logic                   ata_yumi_o,
    output logic                   ata_drop_o,
    output logic                   w_v_o,
    output logic                   w_clr_o,
    output logic [idx_width_p-1:0] w_idx_o,
    output logic [upd_width_p-1:0] w_upd_o,
    input  logic                   w_yumi_i
);

    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam logic [idx_width_p:0]   sweep_last_lp = {1'b0, {idx_width_p{1'b1}}};
    localparam logic [ptr_w_lp-1:0]    ptr_last_lp   = ptr_w_lp'(fifo_els_p - 1);
    localparam logic [cnt_w_lp-1:0]    cnt_full_lp   = cnt_w_lp'(fifo_els_p);

    typedef enum logic {e_init = 1'b0, e_run = 1'b1} state_e;

    state_e                 state_q, state_d;
    // one extra bit so the counter does not wrap on the terminal index
    logic [idx_width_p:0]   sweep_q, sweep_d;
    logic                   init_done_q, init_done_d;

    logic                   skid_v_q, skid_v_d;
    logic                   skid_clr_q, skid_clr_d;
    logic [idx_width_p-1:0] skid_idx_q, skid_idx_d;
    logic [upd_width_p-1:0] skid_upd_q, skid_upd_d;

    logic [idx_width_p-1:0] fifo_idx_q [fifo_els_p];
    logic [upd_width_p-1:0] fifo_upd_q [fifo_els_p];
    logic [ptr_w_lp-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;

    logic run_s, fifo_full_s, fifo_nempty_s;
    logic skid_ret_s, fifo_deq_s, redir_acc_s, ata_enq_s, ata_drop_s;
    logic unused_cfg_s;

    assign unused_cfg_s  = ^bp_params_p;
    assign run_s         = (state_q == e_run);
    assign fifo_full_s   = (cnt_q == cnt_full_lp);
    assign fifo_nempty_s = (cnt_q != {cnt_w_lp{1'b0}});
    // the skid always owns the port when valid, so the FIFO head only
    // retires when the skid is empty
    assign skid_ret_s    = run_s & skid_v_q & w_yumi_i;
    assign fifo_deq_s    = run_s & ~skid_v_q & fifo_nempty_s & w_yumi_i;
    assign redir_acc_s   = run_s & ~skid_v_q & redir_v_i;
    // a head leaving in the same cycle frees the slot for the newcomer
    assign ata_enq_s     = run_s & ata_v_i & (~fifo_full_s | fifo_deq_s);
    assign ata_drop_s    = run_s & ata_v_i & fifo_full_s & ~fifo_deq_s;
    assign init_done_o   = init_done_q;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_init;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave the sweep when the last index is accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            e_init: begin
                if (w_yumi_i && (sweep_q == sweep_last_lp)) begin
                    state_d = e_run;
                end else begin
                    state_d = e_init;
                end
            end
            e_run:   state_d = e_run;
            default: state_d = e_init;
        endcase
    end

    // FSM outputs: write port driven purely from registered state
    always_comb begin
        w_v_o         = 1'b0;
        w_clr_o       = 1'b0;
        w_idx_o       = {idx_width_p{1'b0}};
        w_upd_o       = {upd_width_p{1'b0}};
        redir_ready_o = 1'b0;
        ata_yumi_o    = 1'b0;
        ata_drop_o    = 1'b0;
        case (state_q)
            e_init: begin
                w_v_o   = 1'b1;
                w_clr_o = 1'b1;
                w_idx_o = sweep_q[idx_width_p-1:0];
            end
            e_run: begin
                redir_ready_o = ~skid_v_q;
                ata_yumi_o    = ata_v_i;
                ata_drop_o    = ata_drop_s;
                if (skid_v_q) begin
                    w_v_o   = 1'b1;
                    w_clr_o = skid_clr_q;
                    w_idx_o = skid_idx_q;
                    w_upd_o = skid_clr_q ? {upd_width_p{1'b0}} : skid_upd_q;
                end else if (fifo_nempty_s) begin
                    w_v_o   = 1'b1;
                    w_idx_o = fifo_idx_q[rptr_q];
                    w_upd_o = fifo_upd_q[rptr_q];
                end else begin
                    w_v_o = 1'b0;
                end
            end
            default: begin
                w_v_o = 1'b0;
            end
        endcase
    end

    // next-state for sweep counter, skid and FIFO bookkeeping
    always_comb begin
        sweep_d     = sweep_q;
        init_done_d = (state_d == e_run);
        skid_v_d    = skid_v_q;
        skid_clr_d  = skid_clr_q;
        skid_idx_d  = skid_idx_q;
        skid_upd_d  = skid_upd_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;

        if ((state_q == e_init) && w_yumi_i) begin
            sweep_d = sweep_q + {{idx_width_p{1'b0}}, 1'b1};
        end else begin
            sweep_d = sweep_q;
        end

        // load and retire are mutually exclusive: load needs an empty skid
        if (redir_acc_s) begin
            skid_v_d   = 1'b1;
            skid_clr_d = redir_clr_i;
            skid_idx_d = redir_idx_i;
            skid_upd_d = redir_upd_i;
        end else if (skid_ret_s) begin
            skid_v_d = 1'b0;
        end else begin
            skid_v_d = skid_v_q;
        end

        if (fifo_deq_s) begin
            rptr_d = (rptr_q == ptr_last_lp) ? {ptr_w_lp{1'b0}} : rptr_q + {{(ptr_w_lp-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
        if (ata_enq_s) begin
            wptr_d = (wptr_q == ptr_last_lp) ? {ptr_w_lp{1'b0}} : wptr_q + {{(ptr_w_lp-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end

        case ({ata_enq_s, fifo_deq_s})
            2'b10:   cnt_d = cnt_q + {{(cnt_w_lp-1){1'b0}}, 1'b1};
            2'b01:   cnt_d = cnt_q - {{(cnt_w_lp-1){1'b0}}, 1'b1};
            default: cnt_d = cnt_q;
        endcase
    end

    // control registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sweep_q     <= {(idx_width_p+1){1'b0}};
            init_done_q <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_clr_q  <= 1'b0;
            skid_idx_q  <= {idx_width_p{1'b0}};
            skid_upd_q  <= {upd_width_p{1'b0}};
            rptr_q      <= {ptr_w_lp{1'b0}};
            wptr_q      <= {ptr_w_lp{1'b0}};
            cnt_q       <= {cnt_w_lp{1'b0}};
        end else begin
            sweep_q     <= sweep_d;
            init_done_q <= init_done_d;
            skid_v_q    <= skid_v_d;
            skid_clr_q  <= skid_clr_d;
            skid_idx_q  <= skid_idx_d;
            skid_upd_q  <= skid_upd_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // attaboy FIFO storage; contents are qualified by cnt_q so no reset
    always_ff @(posedge clk_i) begin
        if (ata_enq_s) begin
            fifo_idx_q[wptr_q] <= ata_idx_i;
            fifo_upd_q[wptr_q] <= ata_upd_i;
        end
    end

endmodule

// File: tb/tb_bp_fe_pred_write_sched.sv
module tb_bp_fe_pred_write_sched;

    localparam int IDX = 3;
    localparam int UPD = 8;
    localparam int ELS = 2;

    logic           clk = 1'b0;
    logic           reset_i;
    logic           init_done_o;
    logic           redir_v_i;
    logic [IDX-1:0] redir_idx_i;
    logic [UPD-1:0] redir_upd_i;
    logic           redir_clr_i;
    logic           redir_ready_o;
    logic           ata_v_i;
    logic [IDX-1:0] ata_idx_i;
    logic [UPD-1:0] ata_upd_i;
    logic           ata_yumi_o;
    logic           ata_drop_o;
    logic           w_v_o;
    logic           w_clr_o;
    logic [IDX-1:0] w_idx_o;
    logic [UPD-1:0] w_upd_o;
    logic           w_yumi_i;

    int checks = 0;
    int errors = 0;

    bp_fe_pred_write_sched #(
        .bp_params_p(0),
        .idx_width_p(IDX),
        .upd_width_p(UPD),
        .fifo_els_p (ELS)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .init_done_o  (init_done_o),
        .redir_v_i    (redir_v_i),
        .redir_idx_i  (redir_idx_i),
        .redir_upd_i  (redir_upd_i),
        .redir_clr_i  (redir_clr_i),
        .redir_ready_o(redir_ready_o),
        .ata_v_i      (ata_v_i),
        .ata_idx_i    (ata_idx_i),
        .ata_upd_i    (ata_upd_i),
        .ata_yumi_o   (ata_yumi_o),
        .ata_drop_o   (ata_drop_o),
        .w_v_o        (w_v_o),
        .w_clr_o      (w_clr_o),
        .w_idx_o      (w_idx_o),
        .w_upd_o      (w_upd_o),
        .w_yumi_i     (w_yumi_i)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic           rv;
        logic [IDX-1:0] ridx;
        logic [UPD-1:0] rupd;
        logic           rclr;
        logic           av;
        logic [IDX-1:0] aidx;
        logic [UPD-1:0] aupd;
        logic           yumi;
        logic           e_wv;
        logic [IDX-1:0] e_widx;
        logic           e_wclr;
        logic [UPD-1:0] e_wupd;
        logic           e_rready;
        logic           e_ayumi;
        logic           e_adrop;
    } vec_t;

    typedef struct {
        logic [IDX-1:0] idx;
        logic [UPD-1:0] upd;
        logic           clr;
    } ent_t;

    vec_t vecs[$];
    ent_t rq[$];
    ent_t aq[$];
    int   n_acc = 0;
    int   n_wr  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rv, input logic [IDX-1:0] ridx, input logic [UPD-1:0] rupd,
                                input logic rclr, input logic av, input logic [IDX-1:0] aidx,
                                input logic [UPD-1:0] aupd, input logic yumi, input logic wv,
                                input logic [IDX-1:0] widx, input logic wclr, input logic [UPD-1:0] wupd,
                                input logic rready, input logic ayumi, input logic adrop);
        vec_t v;
        v.rv = rv; v.ridx = ridx; v.rupd = rupd; v.rclr = rclr;
        v.av = av; v.aidx = aidx; v.aupd = aupd; v.yumi = yumi;
        v.e_wv = wv; v.e_widx = widx; v.e_wclr = wclr; v.e_wupd = wupd;
        v.e_rready = rready; v.e_ayumi = ayumi; v.e_adrop = adrop;
        return v;
    endfunction

    task automatic idle_inputs();
        redir_v_i = 1'b0; redir_idx_i = '0; redir_upd_i = '0; redir_clr_i = 1'b0;
        ata_v_i = 1'b0; ata_idx_i = '0; ata_upd_i = '0;
    endtask

    // one reset edge with both sources active; checks reset values
    task automatic apply_reset();
        reset_i = 1'b1; redir_v_i = 1'b1; ata_v_i = 1'b1; w_yumi_i = 1'b1;
        @(posedge clk); #1;
        chk("rst.init_done", init_done_o, 1'b0);
        chk("rst.redir_ready", redir_ready_o, 1'b0);
        chk("rst.ata_yumi", ata_yumi_o, 1'b0);
        chk("rst.ata_drop", ata_drop_o, 1'b0);
        chk("rst.w_v", w_v_o, 1'b1);
        chk("rst.w_clr", w_clr_o, 1'b1);
        chk("rst.w_idx", w_idx_o, 3'd0);
        reset_i = 1'b0;
        idle_inputs();
    endtask

    // run the clear sweep to completion, counting init cycles
    task automatic run_sweep(input bit toggle, input int exp_cycles);
        int n = 0;
        int acc = 0;
        while (n < 200) begin
            w_yumi_i = toggle ? n[0] : 1'b1;
            @(negedge clk);
            if (init_done_o) break;
            chk("sweep.w_v", w_v_o, 1'b1);
            chk("sweep.w_clr", w_clr_o, 1'b1);
            chk("sweep.w_idx", w_idx_o, acc);
            chk("sweep.w_upd", w_upd_o, 8'd0);
            chk("sweep.redir_ready", redir_ready_o, 1'b0);
            if (w_yumi_i) acc++;
            n++;
            @(posedge clk); #1;
        end
        chk("sweep.init_done", init_done_o, 1'b1);
        chk("sweep.cycles", n, exp_cycles);
        chk("sweep.writes", acc, 8);
        chk("sweep.run_idle_w_v", w_v_o, 1'b0);
        w_yumi_i = 1'b0;
        @(posedge clk); #1;
    endtask

    // scoreboard cycle: queues model the skid (rq) and the FIFO (aq)
    task automatic sb_cycle(input logic rv, input logic [IDX-1:0] ridx, input logic [UPD-1:0] rupd,
                            input logic rclr, input logic av, input logic [IDX-1:0] aidx,
                            input logic [UPD-1:0] aupd, input logic yumi);
        logic e_ready, deq, full, enq, e_wv;
        ent_t e;
        redir_v_i = rv; redir_idx_i = ridx; redir_upd_i = rupd; redir_clr_i = rclr;
        ata_v_i = av; ata_idx_i = aidx; ata_upd_i = aupd; w_yumi_i = yumi;
        @(negedge clk);
        e_ready = (rq.size() == 0);
        e_wv    = !e_ready || (aq.size() > 0);
        deq     = e_ready && (aq.size() > 0) && yumi;
        full    = (aq.size() == ELS);
        enq     = av && (!full || deq);
        chk("sb.redir_ready", redir_ready_o, e_ready);
        chk("sb.ata_yumi", ata_yumi_o, av);
        chk("sb.ata_drop", ata_drop_o, av && !enq);
        chk("sb.w_v", w_v_o, e_wv);
        if (e_wv) begin
            e = e_ready ? aq[0] : rq[0];
            chk("sb.w_idx", w_idx_o, e.idx);
            chk("sb.w_clr", w_clr_o, e.clr);
            chk("sb.w_upd", w_upd_o, e.upd);
        end
        if (!e_ready && yumi) begin
            void'(rq.pop_front()); n_wr++;
        end else if (deq) begin
            void'(aq.pop_front()); n_wr++;
        end
        if (rv && e_ready) begin
            e.idx = ridx; e.clr = rclr; e.upd = rclr ? 8'd0 : rupd;
            rq.push_back(e); n_acc++;
        end
        if (enq) begin
            e.idx = aidx; e.clr = 1'b0; e.upd = aupd;
            aq.push_back(e); n_acc++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        // priority, stall hold, overflow, overflow with simultaneous dequeue
        vecs.push_back(mk(0,0,8'h00,0, 1,2,8'h11, 0, 0,0,0,8'h00, 1,1,0));
        vecs.push_back(mk(1,4,8'h55,1, 0,0,8'h00, 0, 1,2,0,8'h11, 1,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 1, 1,4,1,8'h00, 0,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 1, 1,2,0,8'h11, 1,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 0, 0,0,0,8'h00, 1,0,0));
        vecs.push_back(mk(1,6,8'h9A,0, 0,0,8'h00, 0, 0,0,0,8'h00, 1,0,0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 0, 1,6,0,8'h9A, 0,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 1, 1,6,0,8'h9A, 0,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 0, 0,0,0,8'h00, 1,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 1,1,8'h21, 0, 0,0,0,8'h00, 1,1,0));
        vecs.push_back(mk(0,0,8'h00,0, 1,3,8'h23, 0, 1,1,0,8'h21, 1,1,0));
        vecs.push_back(mk(0,0,8'h00,0, 1,5,8'h25, 0, 1,1,0,8'h21, 1,1,1));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 1, 1,1,0,8'h21, 1,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 1, 1,3,0,8'h23, 1,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 0, 0,0,0,8'h00, 1,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 1,1,8'h31, 0, 0,0,0,8'h00, 1,1,0));
        vecs.push_back(mk(0,0,8'h00,0, 1,3,8'h33, 0, 1,1,0,8'h31, 1,1,0));
        vecs.push_back(mk(0,0,8'h00,0, 1,5,8'h35, 1, 1,1,0,8'h31, 1,1,0));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 1, 1,3,0,8'h33, 1,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 1, 1,5,0,8'h35, 1,0,0));
        vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00, 0, 0,0,0,8'h00, 1,0,0));

        reset_i = 1'b1; w_yumi_i = 1'b0;
        idle_inputs();
        @(posedge clk); #1;

        // sweep with constant acceptance
        apply_reset();
        run_sweep(1'b0, 8);

        // reset at index 5 restarts the sweep
        apply_reset();
        w_yumi_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("mid.w_idx5", w_idx_o, 3'd5);
        chk("mid.init_done", init_done_o, 1'b0);
        apply_reset();
        run_sweep(1'b0, 8);

        // sweep with toggling acceptance
        apply_reset();
        run_sweep(1'b1, 16);

        // directed table
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            redir_v_i = v.rv; redir_idx_i = v.ridx; redir_upd_i = v.rupd; redir_clr_i = v.rclr;
            ata_v_i = v.av; ata_idx_i = v.aidx; ata_upd_i = v.aupd; w_yumi_i = v.yumi;
            @(negedge clk);
            chk($sformatf("vec%0d.w_v", i), w_v_o, v.e_wv);
            chk($sformatf("vec%0d.redir_ready", i), redir_ready_o, v.e_rready);
            chk($sformatf("vec%0d.ata_yumi", i), ata_yumi_o, v.e_ayumi);
            chk($sformatf("vec%0d.ata_drop", i), ata_drop_o, v.e_adrop);
            if (v.e_wv) begin
                chk($sformatf("vec%0d.w_idx", i), w_idx_o, v.e_widx);
                chk($sformatf("vec%0d.w_clr", i), w_clr_o, v.e_wclr);
                chk($sformatf("vec%0d.w_upd", i), w_upd_o, v.e_wupd);
            end
            @(posedge clk); #1;
        end
        idle_inputs();

        // back-to-back: redirects on even cycles, attaboys on odd cycles
        for (int i = 0; i < 100; i++) begin
            logic [IDX-1:0] ix;
            logic [UPD-1:0] up;
            logic           cl, y;
            ix = IDX'($urandom_range(0, 7));
            up = UPD'($urandom_range(1, 255));
            cl = ($urandom_range(0, 3) == 0);
            y  = ($urandom_range(0, 3) != 0);
            if (i % 2 == 0) sb_cycle(1'b1, ix, up, cl, 1'b0, '0, '0, y);
            else            sb_cycle(1'b0, '0, '0, 1'b0, 1'b1, ix, up, y);
        end
        for (int i = 0; i < 10; i++) begin
            if (rq.size() + aq.size() == 0) break;
            sb_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        end
        chk("sb.drained", rq.size() + aq.size(), 0);
        chk("sb.writes_vs_accepts", n_wr, n_acc);
        idle_inputs();
        w_yumi_i = 1'b0;
        @(negedge clk);
        chk("sb.final_idle", w_v_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_fe_pred_write_sched.md
# bp_fe_pred_write_sched

Write-port scheduler for the frontend predictor tables (BTB/BHT). It owns the single write port of one table and performs the post-reset clear sweep. It then arbitrates between two update sources: mispredict training from redirects, and correct-prediction training from attaboys. Redirect updates are buffered in a one-entry skid register and always win over attaboys. Attaboy updates are queued in a small FIFO and dropped, never stalled, under overflow.

## Interface
Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration
- idx_width_p, 6, table index width; the clear sweep covers 2^idx_width_p entries
- upd_width_p, 8, opaque update payload width (tag, target, counter, etc.)
- fifo_els_p, 2, attaboy FIFO depth (≥2)

Ports (one clock `clk_i`; `reset_i` is synchronous and active-high):
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- init_done_o  out  1  clear sweep complete; registered
- redir_v_i  in  1  redirect update valid
- redir_idx_i  in  idx_width_p  redirect table index
- redir_upd_i  in  upd_width_p  redirect payload
- redir_clr_i  in  1  redirect invalidates the entry
- redir_ready_o  out  1  skid can accept (ready/valid handshake)
- ata_v_i  in  1  attaboy update valid
- ata_idx_i  in  idx_width_p  attaboy index
- ata_upd_i  in  upd_width_p  attaboy payload
- ata_yumi_o  out  1  attaboy consumed (queued or dropped)
- ata_drop_o  out  1  pulse: consumed attaboy was discarded
- w_v_o  out  1  table write request
- w_clr_o  out  1  write is a clear
- w_idx_o  out  idx_width_p  write index
- w_upd_o  out  upd_width_p  write payload; 0 when w_clr_o
- w_yumi_i  in  1  table accepted write (may be 0 due to read conflict)

## Operation
- States: e_init and e_run.
  - reset_i forces e_init, sweep counter = 0, skid empty, FIFO empty, init_done_o = 0. This holds even if reset arrives mid-sweep or mid-run.
- e_init:
  - w_v_o=1, w_clr_o=1, w_idx_o=counter, w_upd_o=0.
  - Counter advances only on w_yumi_i.
  - On w_yumi_i with counter = 2^idx_width_p−1, go to e_run and set init_done_o=1 the next cycle.
  - Counter is idx_width_p+1 bits wide, so it does not wrap at the terminal index.
  - redir_ready_o=0 and ata_yumi_o=0 throughout e_init.
- e_run write select, fixed priority:
  - If the skid is valid, present the skid entry.
  - Else if the FIFO is non-empty, present the FIFO head with w_clr_o=0.
  - Else w_v_o=0.
  - The selected entry retires only on w_yumi_i. It holds stable while w_yumi_i=0.
- Redirect path:
  - redir_ready_o = e_run & ~skid_v.
  - The skid is loaded on redir_v_i & redir_ready_o and cleared when it retires.
  - There is no bypass, so a redirect cannot write in the same cycle it is accepted.
- Attaboy path:
  - ata_yumi_o = ata_v_i & e_run, combinational. Attaboys are never backpressured in e_run.
  - Enqueue if the FIFO is not full, or if the head retires in the same cycle (simultaneous dequeue frees a slot).
  - Otherwise discard and assert ata_drop_o for that cycle.
- Redirects do not flush the FIFO; queued attaboys remain valid training.
- Both FIFO pointers wrap modulo fifo_els_p. Full/empty are distinguished by a count register.

## Timing
- Reset values: init_done_o=0, redir_ready_o=0, ata_yumi_o=0, ata_drop_o=0, w_v_o=1, w_clr_o=1, w_idx_o=0.
- Clear sweep takes at least 2^idx_width_p cycles, plus one cycle for each w_yumi_i=0.
- Redirect-to-write latency is 1 cycle minimum.
- Attaboy-to-write latency is 1 cycle when the skid and FIFO are empty. The FIFO is registered with no flow-through.
- redir_ready_o, w_v_o, w_idx_o, w_upd_o and w_clr_o depend only on state, so there are no combinational paths from w_yumi_i to them.

## Test plan
- Sweep with idx_width_p=3: release reset, tie w_yumi_i=1. Expect 8 clear writes with idx 0..7, w_upd_o=0, and init_done_o=1 in cycle 9. Repeat with w_yumi_i toggling 1/0 and expect 16 cycles.
- Mid-sweep reset: assert reset_i at idx 5. Expect the sweep to restart at idx 0, init_done_o to stay 0, and no spurious run-mode writes.
- Priority: FIFO holds attaboy A (idx 2), and redirect R (idx 4, clr=1) arrives. Expect the next write to be R with w_clr_o=1, then A, and redir_ready_o=0 for the one cycle R is in the skid.
- Stall hold: present R with w_yumi_i=0 for 3 cycles. Expect w_idx_o/w_upd_o stable and redir_ready_o=0. R retires on the first w_yumi_i=1.
- Overflow (fifo_els_p=2): hold w_yumi_i=0 and send 3 attaboys. Expect 3 ata_yumi_o and ata_drop_o on the 3rd only. Repeat with w_yumi_i=1 on the 3rd cycle and expect no drop.
- Back-to-back: alternate redirects and attaboys every cycle for 100 cycles. The scoreboard checks that every accepted, non-dropped update is written exactly once and that attaboys retire in FIFO order.
